fir_sample_feeder: RTL and testbench

Buffers incoming signed samples from a valid/ready stream and issues them one at a time to the downstream FIR filter stage using the FIR's `input_ready`/`output_ready` pulse protocol. It holds the FIR input word stable for the whole FIR computation. It issues the next sample only after the FIR signals completion, so upstream producers can burst without dropping samples. A watchdog recovers the feeder if the FIR never completes.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_sample_feeder_if.sv | 25 ++
 rtl/sample_fifo.sv | 82 ++++++++
 rtl/fir_sample_feeder.sv | 120 ++++++++++++
 tb/tb_fir_sample_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample feeder.
// Contents: default sample width / tap count, the signed sample type,
// the feeder state encoding and a counter-width helper.
package fir_pkg;

    localparam int unsigned FIR_M = 24;
    localparam int unsigned FIR_N = 16;

    typedef logic signed [FIR_M-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } feeder_state_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Upstream valid/ready sample stream into the feeder.
// Signals: s_data (signed sample), s_valid (producer has a sample),
// s_ready (feeder can accept).
// master = producer side, slave = feeder side.
interface fir_sample_feeder_if #(
    parameter int unsigned M = fir_pkg::FIR_M
);

    logic signed [M-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO of signed samples with wrap-bit pointers.
// Ports:
//   ck, rst     clock, synchronous active-low reset
//   push_i      write wdata_i at the tail (ignored when full)
//   wdata_i     sample to write
//   pop_i       advance the head (ignored when empty)
//   rdata_o     current head sample (valid when not empty)
//   full_o      FIFO holds DEPTH samples
//   empty_o     FIFO holds no samples
//   level_o     current occupancy, 0..DEPTH
module sample_fifo
    import fir_pkg::*;
#(
    parameter int unsigned M     = FIR_M,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic signed [M-1:0]   wdata_i,
    input  logic                  pop_i,
    output logic signed [M-1:0]   rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [LW-1:0]       wptr_q, wptr_d;
    logic [LW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic signed [M-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    // Pointers share the low bits when full or empty; the wrap bit tells them apart.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign level_o = level_q;

    // Next pointer / occupancy values.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        if (do_push) begin
            wptr_d = wptr_q + LW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + LW'(1);
        end
    end

    // Pointer and occupancy registers; reset discards stored samples.
    always_ff @(posedge ck) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers an upstream sample stream and hands samples one at a time to a
// FIR stage using its input_ready / output_ready pulse protocol, with a
// watchdog that abandons a FIR computation that never completes.
// Ports:
//   ck, rst            clock, synchronous active-low reset
//   s_if               upstream valid/ready sample stream (slave side)
//   fir_in             sample presented to the FIR, held until the next pop
//   fir_input_ready    one-cycle start pulse to the FIR
//   fir_output_ready   FIR completion pulse (only honoured while BUSY)
//   level              FIFO occupancy
//   timeout            sticky watchdog-expiry flag, cleared only by reset
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int unsigned M       = FIR_M,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                   ck,
    input  logic                   rst,
    fir_sample_feeder_if.slave     s_if,
    output logic signed [M-1:0]    fir_in,
    output logic                   fir_input_ready,
    input  logic                   fir_output_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    feeder_state_t       state_q, state_d;
    logic signed [M-1:0] fir_in_q, fir_in_d;
    logic                start_q, start_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;
    logic                timeout_q, timeout_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_c;
    logic signed [M-1:0] fifo_head;

    sample_fifo #(
        .M     (M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck      (ck),
        .rst     (rst),
        .push_i  (s_if.s_valid && !fifo_full),
        .wdata_i (s_if.s_data),
        .pop_i   (pop_c),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // Ready depends only on registered fullness, never on a same-cycle pop.
    assign s_if.s_ready    = !fifo_full;

    assign fir_in          = fir_in_q;
    assign fir_input_ready = start_q;
    assign timeout         = timeout_q;

    // Next-state, pop and watchdog logic.
    always_comb begin
        state_d   = state_q;
        fir_in_d  = fir_in_q;
        start_d   = 1'b0;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        pop_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Registering the start pulse here puts it high exactly in ISSUE.
                if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    fir_in_d = fifo_head;
                    start_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wd_cnt_d = '0;
                state_d  = BUSY;
            end
            BUSY: begin
                if (fir_output_ready) begin
                    state_d = IDLE;
                end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q   <= IDLE;
            fir_in_q  <= '0;
            start_q   <= 1'b0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fir_in_q  <= fir_in_d;
            start_q   <= start_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder (M=24, DEPTH=4, TIMEOUT=32).
module tb_fir_sample_feeder;

    localparam int unsigned M       = 24;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned FIR_LAT = 19;

    logic         ck;
    logic         rst;
    logic [M-1:0] fir_in;
    logic         fir_input_ready;
    logic         fir_output_ready;
    logic [2:0]   level;
    logic         timeout;

    logic         fir_or_man;
    logic         model_en;
    logic         model_out;
    logic         model_armed;
    int           model_cnt;

    int           checks;
    int           failures;
    int           cyc;
    int           pulse_cnt;
    int           overlap_cnt;
    int           pulse_cyc[$];
    logic [M-1:0] pulse_val[$];

    fir_sample_feeder_if #(.M(M)) s_if ();

    fir_sample_feeder #(
        .M       (M),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ck               (ck),
        .rst              (rst),
        .s_if             (s_if),
        .fir_in           (fir_in),
        .fir_input_ready  (fir_input_ready),
        .fir_output_ready (fir_output_ready),
        .level            (level),
        .timeout          (timeout)
    );

    assign fir_output_ready = model_en ? model_out : fir_or_man;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Pulse monitor and FIR model: completion FIR_LAT cycles after each start pulse.
    initial begin
        cyc         = 0;
        pulse_cnt   = 0;
        overlap_cnt = 0;
        model_out   = 1'b0;
        model_armed = 1'b0;
        model_cnt   = 0;
        forever begin
            @(posedge ck);
            #1;
            cyc++;
            model_out = 1'b0;
            if (fir_input_ready === 1'b1) begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                pulse_val.push_back(fir_in);
                if (model_armed) overlap_cnt++;
                if (model_en) begin
                    model_armed = 1'b1;
                    model_cnt   = 0;
                end
            end else if (model_armed) begin
                model_cnt++;
                if (model_cnt == FIR_LAT) begin
                    model_out   = 1'b1;
                    model_armed = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within time limit");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         vld;
        logic [M-1:0] data;
        logic         fdone;
        logic         e_rdy;
        logic [2:0]   e_lvl;
        logic         e_pulse;
        logic [M-1:0] e_fir;
        logic         e_to;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic [M-1:0] burst [5];
    int           base;
    int           start_cyc;
    int           extra;

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        fir_or_man = 1'b0;
        model_en   = 1'b0;

        // Inputs sampled at edge k; expected outputs right after edge k.
        //              rst   vld   data          done  rdy   lvl   pulse fir_in        to
        vecs[0]  = '{1'b0, 1'b1, 24'h123456, 1'b0, 1'b1, 3'd0, 1'b0, 24'h000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 24'h654321, 1'b0, 1'b1, 3'd0, 1'b0, 24'h000000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 24'h7FFFFF, 1'b0, 1'b1, 3'd1, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 3'd0, 1'b1, 24'h7FFFFF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 3'd0, 1'b0, 24'h7FFFFF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 3'd0, 1'b0, 24'h7FFFFF, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 24'h000010, 1'b0, 1'b1, 3'd1, 1'b0, 24'h7FFFFF, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 24'hFFFFF0, 1'b0, 1'b1, 3'd1, 1'b1, 24'h000010, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 3'd1, 1'b0, 24'h000010, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 3'd1, 1'b0, 24'h000010, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 3'd0, 1'b1, 24'hFFFFF0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 3'd0, 1'b0, 24'hFFFFF0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 3'd0, 1'b0, 24'hFFFFF0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 3'd0, 1'b0, 24'hFFFFF0, 1'b0};

        burst[0] = 24'h000001;
        burst[1] = 24'hFFFFFF;
        burst[2] = 24'h000002;
        burst[3] = 24'hFFFFFE;
        burst[4] = 24'h000003;

        // Reset, single sample, push+pop at level 1.
        for (int i = 0; i < NV; i++) begin
            rst          = vecs[i].rst;
            s_if.s_valid = vecs[i].vld;
            s_if.s_data  = vecs[i].data;
            fir_or_man   = vecs[i].fdone;
            tick();
            chk($sformatf("vec%0d.s_ready", i), 32'(s_if.s_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d.start", i), 32'(fir_input_ready), 32'(vecs[i].e_pulse));
            chk($sformatf("vec%0d.fir_in", i), 32'(fir_in), 32'(vecs[i].e_fir));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].e_to));
        end
        s_if.s_valid = 1'b0;
        fir_or_man   = 1'b0;

        // Burst of 5 into DEPTH=4 with a 19-cycle FIR.
        model_en  = 1'b1;
        pulse_cyc.delete();
        pulse_val.delete();
        overlap_cnt = 0;
        start_cyc = cyc;
        for (int k = 0; k < 5; k++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = burst[k];
            chk($sformatf("burst.s_ready_before_push%0d", k), 32'(s_if.s_ready), 32'd1);
            tick();
        end
        s_if.s_valid = 1'b0;
        chk("burst.level_full", 32'(level), 32'd4);
        chk("burst.s_ready_full", 32'(s_if.s_ready), 32'd0);
        extra = 0;
        while (pulse_cyc.size() < 5 && extra < 200) begin
            tick();
            extra++;
        end
        chk("burst.pulse_count", 32'(pulse_cyc.size()), 32'd5);
        if (pulse_cyc.size() == 5) begin
            chk("burst.first_latency", 32'(pulse_cyc[0] - start_cyc), 32'd2);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("burst.order%0d", k), 32'(pulse_val[k]), 32'(burst[k]));
                if (k > 0)
                    chk($sformatf("burst.spacing%0d", k), 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd21);
            end
        end
        repeat (25) tick();
        chk("burst.no_start_while_busy", 32'(overlap_cnt), 32'd0);
        chk("burst.no_extra_pulse", 32'(pulse_cyc.size()), 32'd5);
        chk("burst.level_drained", 32'(level), 32'd0);
        chk("burst.timeout_clear", 32'(timeout), 32'd0);
        model_en = 1'b0;

        // Watchdog: FIR never completes; a done pulse during ISSUE is ignored.
        s_if.s_valid = 1'b1;
        s_if.s_data  = 24'h000AAA;
        tick();
        s_if.s_data  = 24'h000BBB;
        tick();
        chk("wd.start_x", 32'(fir_input_ready), 32'd1);
        chk("wd.fir_in_x", 32'(fir_in), 32'h000AAA);
        chk("wd.level_pushpop", 32'(level), 32'd1);
        s_if.s_valid = 1'b0;
        fir_or_man   = 1'b1;
        tick();
        fir_or_man   = 1'b0;
        base = pulse_cnt;
        repeat (31) tick();
        chk("wd.no_early_timeout", 32'(timeout), 32'd0);
        chk("wd.no_pulse_while_waiting", 32'(pulse_cnt - base), 32'd0);
        tick();
        chk("wd.timeout_set", 32'(timeout), 32'd1);
        chk("wd.no_pulse_at_expiry", 32'(fir_input_ready), 32'd0);
        tick();
        chk("wd.next_start", 32'(fir_input_ready), 32'd1);
        chk("wd.next_fir_in", 32'(fir_in), 32'h000BBB);
        chk("wd.timeout_sticky", 32'(timeout), 32'd1);

        // Reset mid-BUSY with three samples queued.
        s_if.s_valid = 1'b1;
        s_if.s_data  = 24'h000111;
        tick();
        s_if.s_data  = 24'h000222;
        tick();
        s_if.s_data  = 24'h000333;
        tick();
        s_if.s_valid = 1'b0;
        chk("rstbusy.level_before", 32'(level), 32'd3);
        rst = 1'b0;
        tick();
        chk("rstbusy.level", 32'(level), 32'd0);
        chk("rstbusy.start", 32'(fir_input_ready), 32'd0);
        chk("rstbusy.s_ready", 32'(s_if.s_ready), 32'd1);
        chk("rstbusy.fir_in", 32'(fir_in), 32'd0);
        chk("rstbusy.timeout", 32'(timeout), 32'd0);
        rst  = 1'b1;
        base = pulse_cnt;
        repeat (60) tick();
        chk("rstbusy.no_pulses_after", 32'(pulse_cnt - base), 32'd0);
        chk("rstbusy.level_after", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
